// File: rtl/cpu6_core.sv
// cpu6_core: accumulator CPU with 16-bit registers on an 8-bit memory bus.
// One bus byte per clock; bus outputs are registered together with the next FSM state.
module cpu6_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  dataInBus,
  output logic        writeEnBus,
  output logic [15:0] addressBus,
  output logic [7:0]  dataOutBus
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    OPER    = 3'd1,
    DATA_RD = 3'd2,
    DATA_WR = 3'd3,
    EXEC    = 3'd4,
    HALT    = 3'd5
  } state_t;

  // Opcodes that read at least one operand byte after the fetch.
  function automatic logic has_operand(input logic [7:0] op);
    case (op)
      8'h14, 8'h15, 8'h16, 8'h17,
      8'h71, 8'h80, 8'h81, 8'h90,
      8'h91, 8'hA1, 8'hB1: has_operand = 1'b1;
      default:             has_operand = 1'b0;
    endcase
  endfunction

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_z;
  logic        r_m;
  logic        r_c;
  logic [7:0]  r_op;
  logic [7:0]  r_hi;
  logic        r_idx;
  logic [15:0] r_addr;
  logic        r_we;
  logic [7:0]  r_dout;

  logic [15:0] w_pc_inc;
  logic [15:0] w_addr_inc;
  logic [15:0] w_word;
  logic [15:0] w_target;
  logic [16:0] w_inc;
  logic [16:0] w_dec;
  logic [16:0] w_add;
  logic        w_taken;

  assign w_pc_inc   = r_pc + 16'd1;
  assign w_addr_inc = r_addr + 16'd1;
  assign w_word     = {r_hi, dataInBus};
  assign w_target   = w_pc_inc + {{8{dataInBus[7]}}, dataInBus};
  assign w_inc      = {1'b0, r_a} + 17'd1;
  assign w_dec      = {1'b0, r_a} - 17'd1;
  assign w_add      = {1'b0, r_a} + {1'b0, r_b};

  assign addressBus = r_addr;
  assign writeEnBus = r_we;
  assign dataOutBus = r_dout;

  // Branch condition: BZ, BNZ, BM, BP selected by the low opcode bits.
  always_comb begin
    w_taken = 1'b0;
    case (r_op[1:0])
      2'd0:    w_taken = r_z;
      2'd1:    w_taken = ~r_z;
      2'd2:    w_taken = r_m;
      2'd3:    w_taken = ~r_m;
      default: w_taken = 1'b0;
    endcase
  end

  // Instruction sequencer, architectural state and registered bus outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_z     <= 1'b0;
      r_m     <= 1'b0;
      r_c     <= 1'b0;
      r_op    <= 8'h00;
      r_hi    <= 8'h00;
      r_idx   <= 1'b0;
      r_addr  <= RESET_PC;
      r_we    <= 1'b0;
      r_dout  <= 8'h00;
    end else begin
      case (r_state)
        FETCH: begin
          r_op    <= dataInBus;
          r_pc    <= w_pc_inc;
          r_addr  <= w_pc_inc;
          r_idx   <= 1'b0;
          r_state <= has_operand(dataInBus) ? OPER : EXEC;
        end

        OPER: begin
          r_pc   <= w_pc_inc;
          r_addr <= w_pc_inc;
          case (r_op)
            8'h14, 8'h15, 8'h16, 8'h17: begin
              r_state <= FETCH;
              if (w_taken) begin
                r_pc   <= w_target;
                r_addr <= w_target;
              end else begin
                r_pc   <= w_pc_inc;
                r_addr <= w_pc_inc;
              end
            end
            8'h80: begin
              r_a[7:0] <= dataInBus;
              r_z      <= (dataInBus == 8'h00);
              r_m      <= dataInBus[7];
              r_state  <= FETCH;
            end
            default: begin
              if (!r_idx) begin
                r_hi  <= dataInBus;
                r_idx <= 1'b1;
              end else begin
                r_idx <= 1'b0;
                case (r_op)
                  8'h90: begin
                    r_a     <= w_word;
                    r_z     <= (w_word == 16'h0000);
                    r_m     <= w_word[15];
                    r_state <= FETCH;
                  end
                  8'h71: begin
                    r_pc    <= w_word;
                    r_addr  <= w_word;
                    r_state <= FETCH;
                  end
                  8'h81, 8'h91: begin
                    r_addr  <= w_word;
                    r_state <= DATA_RD;
                  end
                  8'hA1: begin
                    r_addr  <= w_word;
                    r_we    <= 1'b1;
                    r_dout  <= r_a[7:0];
                    r_state <= DATA_WR;
                  end
                  8'hB1: begin
                    r_addr  <= w_word;
                    r_we    <= 1'b1;
                    r_dout  <= r_a[15:8];
                    r_state <= DATA_WR;
                  end
                  default: r_state <= FETCH;
                endcase
              end
            end
          endcase
        end

        DATA_RD: begin
          if (r_op == 8'h81) begin
            r_a[7:0] <= dataInBus;
            r_z      <= (dataInBus == 8'h00);
            r_m      <= dataInBus[7];
            r_addr   <= r_pc;
            r_state  <= FETCH;
          end else if (!r_idx) begin
            r_hi   <= dataInBus;
            r_idx  <= 1'b1;
            r_addr <= w_addr_inc;
          end else begin
            r_a     <= w_word;
            r_z     <= (w_word == 16'h0000);
            r_m     <= w_word[15];
            r_idx   <= 1'b0;
            r_addr  <= r_pc;
            r_state <= FETCH;
          end
        end

        // STA keeps writing for a second byte (AL at EA+1); all other writes end here.
        DATA_WR: begin
          if ((r_op == 8'hB1) && !r_idx) begin
            r_addr <= w_addr_inc;
            r_dout <= r_a[7:0];
            r_idx  <= 1'b1;
          end else begin
            r_we    <= 1'b0;
            r_dout  <= 8'h00;
            r_idx   <= 1'b0;
            r_addr  <= r_pc;
            r_state <= FETCH;
          end
        end

        EXEC: begin
          r_addr  <= r_pc;
          r_state <= FETCH;
          case (r_op)
            8'h00: r_state <= HALT;
            8'h38: begin
              r_a <= w_inc[15:0];
              r_c <= w_inc[16];
              r_z <= (w_inc[15:0] == 16'h0000);
              r_m <= w_inc[15];
            end
            8'h39: begin
              r_a <= w_dec[15:0];
              r_c <= w_dec[16];
              r_z <= (w_dec[15:0] == 16'h0000);
              r_m <= w_dec[15];
            end
            8'h3A: begin
              r_a <= 16'h0000;
              r_z <= 1'b1;
              r_m <= 1'b0;
            end
            8'h58: begin
              r_a <= w_add[15:0];
              r_c <= w_add[16];
              r_z <= (w_add[15:0] == 16'h0000);
              r_m <= w_add[15];
            end
            8'h5C:   r_b <= r_a;
            default: r_state <= FETCH;
          endcase
        end

        HALT: r_state <= HALT;

        default: begin
          r_state <= FETCH;
          r_addr  <= r_pc;
          r_we    <= 1'b0;
          r_dout  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6_core.sv
// Self-checking bench for cpu6_core: directed programs, a reset-abort case and
// random forward-only programs checked against an instruction-level model.
module tb_cpu6_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  dataInBus;
  logic        writeEnBus;
  logic [15:0] addressBus;
  logic [7:0]  dataOutBus;

  logic [7:0] mem [0:65535];
  logic [7:0] mm  [0:65535];

  assign dataInBus = mem[addressBus];
  always #5 clock = ~clock;

  cpu6_core #(.RESET_PC(16'h0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .dataInBus  (dataInBus),
    .writeEnBus (writeEnBus),
    .addressBus (addressBus),
    .dataOutBus (dataOutBus)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t obs_wr[$];
  wr_t exp_wr[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  logic        pend_we = 1'b0;
  logic [15:0] pend_a = 16'h0000;
  logic [7:0]  pend_d = 8'h00;

  logic [15:0] m_pc, m_a, m_b;
  logic        m_z, m_m, m_c;
  int          m_cycles;
  bit          m_ok;

  logic [63:0] dprog [5];
  int          dlen  [5];
  logic [15:0] dA [5];
  logic [15:0] dB [5];
  logic [15:0] dHalt [5];
  logic [2:0]  dF [5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: commit the write seen in the previous half cycle, then sample outputs.
  task automatic step();
    @(posedge clock);
    if (pend_we) begin
      mem[pend_a] = pend_d;
      obs_wr.push_back(wr_t'{32'(cyc), pend_a, pend_d});
    end
    cyc++;
    @(negedge clock);
    pend_we = writeEnBus;
    pend_a  = addressBus;
    pend_d  = dataOutBus;
  endtask

  task automatic apply_reset(input string tag);
    reset   = 1'b1;
    pend_we = 1'b0;
    #1;
    chk({tag, "/rst_addr"}, 64'(addressBus), 64'h0000);
    chk({tag, "/rst_we"},   64'(writeEnBus), 64'h0);
    chk({tag, "/rst_dout"}, 64'(dataOutBus), 64'h00);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cyc   = 0;
    obs_wr.delete();
    pend_we = writeEnBus;
    pend_a  = addressBus;
    pend_d  = dataOutBus;
  endtask

  function automatic logic [15:0] rd16(input logic [15:0] ea);
    return {mm[ea], mm[ea + 16'd1]};
  endfunction

  task automatic model_write(input int t, input logic [15:0] ea, input logic [7:0] d);
    mm[ea] = d;
    exp_wr.push_back(wr_t'{32'(t), ea, d});
  endtask

  task automatic flags16(input logic [15:0] v);
    m_z = (v == 16'h0000);
    m_m = v[15];
  endtask

  // Instruction-level interpreter: whole instructions, cycle totals and byte writes.
  task automatic run_model();
    int t;
    int tmp;
    logic [7:0]  op, d;
    logic [15:0] ea;
    bit taken;
    t = 0; m_pc = 16'h0000; m_a = 16'h0000; m_b = 16'h0000;
    m_z = 1'b0; m_m = 1'b0; m_c = 1'b0; m_ok = 1'b0;
    exp_wr.delete();
    for (int i = 0; i < 65536; i++) mm[i] = mem[i];
    for (int it = 0; it < 1000 && !m_ok; it++) begin
      op = mm[m_pc];
      m_pc = m_pc + 16'd1;
      case (op)
        8'h00: begin m_ok = 1'b1; t += 2; end
        8'h14, 8'h15, 8'h16, 8'h17: begin
          d = mm[m_pc];
          m_pc = m_pc + 16'd1;
          case (op)
            8'h14:   taken = m_z;
            8'h15:   taken = !m_z;
            8'h16:   taken = m_m;
            default: taken = !m_m;
          endcase
          if (taken) m_pc = 16'(int'(m_pc) + int'($signed(d)));
          t += 2;
        end
        8'h38: begin tmp = int'(m_a) + 1; m_c = (tmp > 65535); m_a = 16'(tmp); flags16(m_a); t += 2; end
        8'h39: begin m_c = (m_a == 16'h0000); m_a = 16'(int'(m_a) - 1); flags16(m_a); t += 2; end
        8'h3A: begin m_a = 16'h0000; flags16(m_a); t += 2; end
        8'h58: begin tmp = int'(m_a) + int'(m_b); m_c = (tmp > 65535); m_a = 16'(tmp); flags16(m_a); t += 2; end
        8'h5C: begin m_b = m_a; t += 2; end
        8'h71: begin m_pc = rd16(m_pc); t += 3; end
        8'h80: begin
          d = mm[m_pc]; m_pc = m_pc + 16'd1;
          m_a = {m_a[15:8], d}; m_z = (d == 8'h00); m_m = d[7]; t += 2;
        end
        8'h81: begin
          ea = rd16(m_pc); m_pc = m_pc + 16'd2;
          d = mm[ea]; m_a = {m_a[15:8], d}; m_z = (d == 8'h00); m_m = d[7]; t += 4;
        end
        8'h90: begin m_a = rd16(m_pc); m_pc = m_pc + 16'd2; flags16(m_a); t += 3; end
        8'h91: begin ea = rd16(m_pc); m_pc = m_pc + 16'd2; m_a = rd16(ea); flags16(m_a); t += 5; end
        8'hA1: begin ea = rd16(m_pc); m_pc = m_pc + 16'd2; model_write(t + 3, ea, m_a[7:0]); t += 4; end
        8'hB1: begin
          ea = rd16(m_pc); m_pc = m_pc + 16'd2;
          model_write(t + 3, ea, m_a[15:8]);
          model_write(t + 4, ea + 16'd1, m_a[7:0]);
          t += 5;
        end
        default: t += 2;
      endcase
    end
    m_cycles = t;
  endtask

  task automatic run_and_check(input string tag);
    int diffs;
    run_model();
    if (!m_ok) begin
      n_fail++;
      $display("FAIL %s: reference program did not halt", tag);
    end
    apply_reset(tag);
    repeat (m_cycles - 2) step();
    chk({tag, "/hlt_fetch_addr"}, 64'(addressBus), 64'(m_pc - 16'd1));
    repeat (2) step();
    chk({tag, "/halt_addr"}, 64'(addressBus), 64'(m_pc));
    chk({tag, "/halt_we"},   64'(writeEnBus), 64'h0);
    chk({tag, "/A"}, 64'(dut.r_a), 64'(m_a));
    chk({tag, "/B"}, 64'(dut.r_b), 64'(m_b));
    chk({tag, "/ZMC"}, 64'({dut.r_z, dut.r_m, dut.r_c}), 64'({m_z, m_m, m_c}));
    repeat (3) step();
    chk({tag, "/hold_addr"}, 64'(addressBus), 64'(m_pc));
    chk({tag, "/n_writes"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++)
      chk($sformatf("%s/write%0d", tag, k), 64'(obs_wr[k]), 64'(exp_wr[k]));
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== mm[i]) diffs++;
    chk({tag, "/mem_diffs"}, 64'(diffs), 64'h0);
  endtask

  function automatic logic [7:0] pool_op(input int p);
    case (p)
      0: return 8'h01;  1: return 8'h14;  2: return 8'h15;  3: return 8'h16;
      4: return 8'h17;  5: return 8'h38;  6: return 8'h39;  7: return 8'h3A;
      8: return 8'h58;  9: return 8'h5C; 10: return 8'h71; 11: return 8'h80;
      12: return 8'h81; 13: return 8'h90; 14: return 8'h91; 15: return 8'hA1;
      default: return 8'hB1;
    endcase
  endfunction

  function automatic bit is_defined(input logic [7:0] op);
    for (int p = 0; p < 17; p++) if (pool_op(p) == op) return 1'b1;
    return (op == 8'h00);
  endfunction

  function automatic int oplen(input logic [7:0] op);
    case (op)
      8'h14, 8'h15, 8'h16, 8'h17, 8'h80: return 2;
      8'h71, 8'h81, 8'h90, 8'h91, 8'hA1, 8'hB1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int pick16();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 65535;
      2: return 32768;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  // Random program whose branches and jumps only go forward, so it always reaches HLT.
  task automatic gen_random();
    logic [7:0] ops [33];
    int st [34];
    int k, j, v;
    logic [7:0] u;
    k = $urandom_range(6, 20);
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem[32768 + i] = 8'($urandom);
    mem[16'hFFFF] = 8'($urandom);
    st[0] = 0;
    for (int i = 0; i < k; i++) begin
      v = $urandom_range(0, 17);
      if (v == 17) begin
        do u = 8'($urandom); while (is_defined(u));
        ops[i] = u;
      end else begin
        ops[i] = pool_op(v);
      end
      st[i + 1] = st[i] + oplen(ops[i]);
    end
    ops[k] = 8'h00;
    for (int i = 0; i <= k; i++) mem[st[i]] = ops[i];
    for (int i = 0; i < k; i++) begin
      case (ops[i])
        8'h14, 8'h15, 8'h16, 8'h17: begin
          j = $urandom_range(i + 1, k);
          mem[st[i] + 1] = 8'(st[j] - (st[i] + 2));
        end
        8'h71: begin
          j = $urandom_range(i + 1, k);
          mem[st[i] + 1] = 8'(st[j] >> 8);
          mem[st[i] + 2] = 8'(st[j]);
        end
        8'h80: mem[st[i] + 1] = 8'(pick16());
        8'h90: begin
          v = pick16();
          mem[st[i] + 1] = 8'(v >> 8);
          mem[st[i] + 2] = 8'(v);
        end
        8'h81, 8'h91, 8'hA1, 8'hB1: begin
          v = ($urandom_range(0, 5) == 0) ? 65535 : 32768 + int'($urandom_range(0, 255));
          mem[st[i] + 1] = 8'(v >> 8);
          mem[st[i] + 2] = 8'(v);
        end
        default: ;
      endcase
    end
  endtask

  task automatic load_directed(input int n);
    logic [63:0] p;
    p = dprog[n];
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < dlen[n]; i++) mem[i] = p[63 - 8 * i -: 8];
  endtask

  initial begin
    string tag;
    dprog = '{64'h805A000000000000, 64'h901234B101000000, 64'h90FFFF3800000000,
              64'h3A14020000800100, 64'h9000055C58000000};
    dlen  = '{3, 7, 5, 8, 6};
    dA    = '{16'h005A, 16'h1234, 16'h0000, 16'h0001, 16'h000A};
    dB    = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005};
    dF    = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b000};
    dHalt = '{16'h0003, 16'h0007, 16'h0005, 16'h0008, 16'h0006};
    #1;

    for (int n = 0; n < 5; n++) begin
      tag = $sformatf("dir%0d", n);
      load_directed(n);
      run_and_check(tag);
      chk({tag, "/A_const"}, 64'(dut.r_a), 64'(dA[n]));
      chk({tag, "/B_const"}, 64'(dut.r_b), 64'(dB[n]));
      chk({tag, "/ZMC_const"}, 64'({dut.r_z, dut.r_m, dut.r_c}), 64'(dF[n]));
      chk({tag, "/halt_const"}, 64'(addressBus), 64'(dHalt[n]));
      if (n == 1) begin
        chk("dir1/n_pulses", 64'(obs_wr.size()), 64'd2);
        if (obs_wr.size() == 2) begin
          chk("dir1/w0", 64'({obs_wr[0].addr, obs_wr[0].data}), 64'h010012);
          chk("dir1/w1", 64'({obs_wr[1].addr, obs_wr[1].data}), 64'h010134);
        end
      end
    end

    // Reset asserted mid-cycle while STA drives its first write.
    load_directed(1);
    apply_reset("abort");
    repeat (6) step();
    chk("abort/we_before", 64'(writeEnBus), 64'h1);
    chk("abort/ea_before", 64'(addressBus), 64'h0100);
    reset   = 1'b1;
    pend_we = 1'b0;
    #1;
    chk("abort/we_drop", 64'(writeEnBus), 64'h0);
    chk("abort/addr_rst", 64'(addressBus), 64'h0000);
    chk("abort/dout_rst", 64'(dataOutBus), 64'h00);
    @(posedge clock);
    #1;
    chk("abort/no_write", 64'(mem[16'h0100]), 64'h00);
    run_and_check("abort_rerun");

    for (int n = 0; n < 25; n++) begin
      gen_random();
      run_and_check($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu6_core.md
CPU6_CORE -- requirements
Module: cpu6_core

Interface
REQ-001 The design SHALL have one clock; reset is asynchronous and active-high. Ports are named clock and reset.
REQ-002 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 dataInBus  input  8  memory read data; combinational function of addressBus, sampled at the next rising edge.
REQ-006 writeEnBus  output  1  high for exactly one cycle per byte written; memory writes dataOutBus to addressBus on that rising edge.
REQ-007 addressBus  output  16  byte address of the current bus cycle.
REQ-008 dataOutBus  output  8  write data; valid whenever writeEnBus=1.

Function
REQ-009 Architectural state: PC[15:0]; A[15:0] (AH=A[15:8], AL=A[7:0]); B[15:0]; flags Z, M, C.
REQ-010 Multi-cycle FSM, one bus byte per clock, with states FETCH, OPER, DATA_RD, DATA_WR, EXEC and HALT.
- FETCH: addressBus=PC; latch opcode; PC+1.
- OPER: reads each operand byte at PC; PC+1 per byte.
- DATA_RD/DATA_WR: access the effective address.
- EXEC: implied instructions only.
REQ-011 Multi-byte operands and data are big-endian: high byte at the lower address. A 16-bit data access touches EA then EA+1, with EA+1 wrapping modulo 2^16.
REQ-012 Opcodes:
- 00 HLT
- 01 NOP
- 14 BZ, 15 BNZ, 16 BM, 17 BP (taken when M=0): imm8 signed displacement. If taken, PC = PC after the operand + sign-extended displacement, mod 2^16.
- 38 INA: A=A+1. 39 DCA: A=A-1.
- 3A CLA: A=0.
- 58 ADD: A=A+B.
- 5C XAB: B=A.
- 71 JMP addr16: PC=addr.
- 80 LDAL #imm8. 81 LDAL addr16.
- 90 LDA #imm16. 91 LDA addr16.
- A1 STAL addr16. B1 STA addr16.
REQ-013 Any undefined opcode SHALL execute as NOP (2 cycles).
REQ-014 Cycle counts, fetch included:
- 2 cycles: implied ops, imm8 loads, branches taken or not.
- 3 cycles: LDA #, JMP.
- 4 cycles: LDAL addr, STAL.
- 5 cycles: LDA addr, STA.
REQ-015 Flags:
- Loads, CLA, INA, DCA, ADD: Z = result==0; M = result MSB. Both use bit 7 for 8-bit LDAL and 16 bits otherwise.
- C: carry-out for INA and ADD; borrow for DCA.
- Loads and CLA leave C unchanged. XAB, stores and branches leave all flags unchanged.
REQ-016 LDAL SHALL modify AL only; AH is preserved.
REQ-017 Arithmetic wraps at 16 bits: FFFF+1 = 0000 with C=1; 0000-1 = FFFF with C=1.
REQ-018 Stores: STAL writes AL. STA writes AH then AL.
- writeEnBus is asserted only in DATA_WR cycles.
- dataOutBus = 8'h00 when not writing.
REQ-019 HLT SHALL enter HALT. HALT persists until reset:
- addressBus holds the PC after HLT.
- writeEnBus=0.
- No state changes.
REQ-020 In non-write cycles writeEnBus=0 and addressBus follows the current state: PC, or the effective address.

Reset
REQ-021 While reset=1, asynchronously and independent of clock:
- PC=RESET_PC; A=B=0; Z=M=C=0; state=FETCH.
- writeEnBus=0; dataOutBus=0; addressBus=RESET_PC.
REQ-022 Reset asserted mid-instruction or mid-write SHALL abort immediately. An aborted write is not performed if reset is asserted before the write edge.
REQ-023 After reset deasserts, the first rising edge SHALL perform FETCH at RESET_PC.

Verification
REQ-024 Memory holds 80 5A 00 -> after 2 cycles AL=5A, Z=0, M=0; HLT is fetched at 0002; addressBus then holds 0003 with writeEnBus low.
REQ-025 Memory holds 90 12 34 B1 01 00 00 -> exactly two writeEnBus pulses: (0100,12) then (0101,34); next fetch from 0006 is HLT.
REQ-026 Memory holds 90 FF FF 38 00 -> A=0000, Z=1, C=1, M=0.
REQ-027 Memory holds 3A 14 02 00 00 80 01 00 -> CLA sets Z=1; BZ is taken to 0005; final AL=01.
REQ-028 Memory holds 90 00 05 5C 58 00 -> B=0005, A=000A, C=0.
REQ-029 Reset pulse during the DATA_WR cycle of STA -> writeEnBus drops immediately; addressBus=RESET_PC; the program restarts cleanly.
